// File: rtl/pipe_emreg_fwd_if.sv
// EXE/MEM boundary bundle: EXE-stage results in, MEM-stage register and
// decode hazard controls out. The pipeline register (slave) uses the slave modport.
interface pipe_emreg_fwd_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    // EXE stage results
    logic          ewreg;
    logic          em2reg;
    logic          ewmem;
    logic [DW-1:0] ealu;
    logic [DW-1:0] eb;
    logic [RW-1:0] ern;
    logic          mem_hold;

    // decode-stage source operands
    logic [RW-1:0] drs;
    logic [RW-1:0] drt;
    logic          duse_rs;
    logic          duse_rt;

    // MEM stage register
    logic          mwreg;
    logic          mm2reg;
    logic          mwmem;
    logic [DW-1:0] malu;
    logic [DW-1:0] mb;
    logic [RW-1:0] mrn;

    // hazard control back to decode
    logic [1:0]    fwda;
    logic [1:0]    fwdb;
    logic          stall;

    modport master (
        output ewreg, em2reg, ewmem, ealu, eb, ern, mem_hold,
        output drs, drt, duse_rs, duse_rt,
        input  mwreg, mm2reg, mwmem, malu, mb, mrn,
        input  fwda, fwdb, stall
    );

    modport slave (
        input  ewreg, em2reg, ewmem, ealu, eb, ern, mem_hold,
        input  drs, drt, duse_rs, duse_rt,
        output mwreg, mm2reg, mwmem, malu, mb, mrn,
        output fwda, fwdb, stall
    );
endinterface

// File: rtl/pipe_emreg_fwd.sv
// EXE/MEM pipeline register with forwarding-select and load-use stall generation.
// Optional hazard counters (stall_cnt, fwd_cnt) are enabled by PIPE_HAZARD_CNT_EN.
module pipe_emreg_fwd #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic              clock,
    input  logic              resetn,
    pipe_emreg_fwd_if.slave   bus
`ifdef PIPE_HAZARD_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic          wmem;
        logic [DW-1:0] alu;
        logic [DW-1:0] b;
        logic [RW-1:0] rn;
    } mreg_t;

    mreg_t m_q, m_d;

    // A load in EXE that matches the source reports 00; decode is stalled and
    // picks up the 11 select once the load reaches MEM.
    function automatic logic [1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic          use_src,
        input logic          e_wreg,
        input logic          e_m2reg,
        input logic [RW-1:0] e_rn,
        input mreg_t         m
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src) begin
            if (e_wreg && (e_rn != '0) && (e_rn == src)) begin
                sel = e_m2reg ? 2'b00 : 2'b01;
            end else if (m.wreg && (m.rn != '0) && (m.rn == src)) begin
                sel = m.m2reg ? 2'b11 : 2'b10;
            end
        end
        return sel;
    endfunction

    logic load_in_exe;
    logic load_use;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        m_d = m_q;
        if (!bus.mem_hold) begin
            m_d.wreg  = bus.ewreg;
            m_d.m2reg = bus.em2reg;
            m_d.wmem  = bus.ewmem;
            m_d.alu   = bus.ealu;
            m_d.b     = bus.eb;
            m_d.rn    = bus.ern;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            m_q <= '0;
        end else begin
            m_q <= m_d;
        end
    end

    always_comb begin
        load_in_exe = bus.ewreg && bus.em2reg && (bus.ern != '0);
        load_use    = load_in_exe &&
                      ((bus.duse_rs && (bus.ern == bus.drs)) ||
                       (bus.duse_rt && (bus.ern == bus.drt)));
    end

    assign bus.fwda   = fwd_sel(bus.drs, bus.duse_rs, bus.ewreg, bus.em2reg, bus.ern, m_q);
    assign bus.fwdb   = fwd_sel(bus.drt, bus.duse_rt, bus.ewreg, bus.em2reg, bus.ern, m_q);
    assign bus.stall  = load_use || bus.mem_hold;

    assign bus.mwreg  = m_q.wreg;
    assign bus.mm2reg = m_q.m2reg;
    assign bus.mwmem  = m_q.wmem;
    assign bus.malu   = m_q.alu;
    assign bus.mb     = m_q.b;
    assign bus.mrn    = m_q.rn;

`ifdef PIPE_HAZARD_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    // Hold cycles are not load-use stalls, so only the latter are counted.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (load_use && !bus.mem_hold) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((bus.fwda != 2'b00) || (bus.fwdb != 2'b00)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_emreg_fwd.sv
// Self-checking bench for pipe_emreg_fwd: directed scenarios plus a randomized
// run against a behavioural model of the MEM register and hazard rules.
module tb_pipe_emreg_fwd;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    pipe_emreg_fwd_if #(.DW(32), .RW(5)) bus ();

`ifdef PIPE_HAZARD_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    pipe_emreg_fwd #(.DW(32), .RW(5)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus)
`ifdef PIPE_HAZARD_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what the MEM stage should hold.
    logic        exp_mwreg  = 1'b0;
    logic        exp_mm2reg = 1'b0;
    logic        exp_mwmem  = 1'b0;
    logic [31:0] exp_malu   = '0;
    logic [31:0] exp_mb     = '0;
    logic [4:0]  exp_mrn    = '0;
    logic [31:0] exp_stall_cnt = '0;
    logic [31:0] exp_fwd_cnt   = '0;

    // Hazard rules as read from the pipeline description: register 0 is never a
    // real dependency; a producer in EXE outranks one in MEM; a load still in EXE
    // cannot be forwarded yet.
    function automatic logic [1:0] ref_sel(input logic [4:0] src, input logic use_src);
        if (!use_src || src == 5'd0) return 2'b00;
        if (bus.ewreg && bus.ern == src) return bus.em2reg ? 2'b00 : 2'b01;
        if (exp_mwreg && exp_mrn == src) return exp_mm2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic ref_load_use();
        if (!(bus.ewreg && bus.em2reg) || bus.ern == 5'd0) return 1'b0;
        return (bus.duse_rs && bus.ern == bus.drs) || (bus.duse_rt && bus.ern == bus.drt);
    endfunction

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic tick();
        logic lu;
        logic fw;
        lu = ref_load_use();
        fw = (ref_sel(bus.drs, bus.duse_rs) != 2'b00) || (ref_sel(bus.drt, bus.duse_rt) != 2'b00);
        if (!resetn) begin
            exp_mwreg = 0; exp_mm2reg = 0; exp_mwmem = 0;
            exp_malu = 0; exp_mb = 0; exp_mrn = 0;
            exp_stall_cnt = 0; exp_fwd_cnt = 0;
        end else begin
            if (!bus.mem_hold) begin
                exp_mwreg = bus.ewreg; exp_mm2reg = bus.em2reg; exp_mwmem = bus.ewmem;
                exp_malu = bus.ealu; exp_mb = bus.eb; exp_mrn = bus.ern;
            end
            if (lu && !bus.mem_hold) exp_stall_cnt = exp_stall_cnt + 1;
            if (fw) exp_fwd_cnt = exp_fwd_cnt + 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ewreg = 0; bus.em2reg = 0; bus.ewmem = 0;
        bus.ealu = 0; bus.eb = 0; bus.ern = 0; bus.mem_hold = 0;
        bus.drs = 0; bus.drt = 0; bus.duse_rs = 0; bus.duse_rt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        bus.ewreg = 1; bus.ealu = 32'h1234; bus.ern = 5'd5;
        tick();
        checks++;
        if (bus.malu !== 32'h0 || bus.mrn !== 5'd0 || bus.mwreg !== 1'b0 ||
            bus.mm2reg !== 1'b0 || bus.mwmem !== 1'b0 || bus.mb !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: malu=%h mrn=%0d mwreg=%b mm2reg=%b mwmem=%b mb=%h, required all 0",
                     bus.malu, bus.mrn, bus.mwreg, bus.mm2reg, bus.mwmem, bus.mb);
        end
        checks++;
        if (bus.stall !== 1'b0 || bus.fwda !== 2'b00 || bus.fwdb !== 2'b00) begin
            errors++;
            $display("FAIL reset_hazard: stall=%b fwda=%b fwdb=%b, required 0 00 00",
                     bus.stall, bus.fwda, bus.fwdb);
        end
        resetn = 1;
        tick();
        checks++;
        if (bus.malu !== 32'h1234 || bus.mrn !== 5'd5 || bus.mwreg !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: malu=%h mrn=%0d mwreg=%b, required 00001234 5 1",
                     bus.malu, bus.mrn, bus.mwreg);
        end
    endtask

    task automatic test_exe_fwd();
        bus.ewreg = 1; bus.em2reg = 0; bus.ern = 5'd8;
        bus.drs = 5'd8; bus.duse_rs = 1; bus.drt = 5'd9; bus.duse_rt = 1;
        #1;
        checks++;
        if (bus.fwda !== 2'b01 || bus.fwdb !== 2'b00 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL exe_fwd: fwda=%b fwdb=%b stall=%b, required 01 00 0", bus.fwda, bus.fwdb, bus.stall);
        end
        bus.ern = 5'd0; bus.drs = 5'd0;
        #1;
        checks++;
        if (bus.fwda !== 2'b00) begin
            errors++;
            $display("FAIL exe_fwd_r0: fwda=%b, required 00", bus.fwda);
        end
    endtask

    task automatic test_priority();
        bus.ewreg = 1; bus.em2reg = 0; bus.ern = 5'd3;
        bus.drs = 5'd0; bus.duse_rs = 0; bus.drt = 5'd3; bus.duse_rt = 1;
        tick();
        checks++;
        if (bus.fwdb !== 2'b01) begin
            errors++;
            $display("FAIL prio_exe_over_mem: fwdb=%b, required 01", bus.fwdb);
        end
        bus.ewreg = 0;
        #1;
        checks++;
        if (bus.fwdb !== 2'b10) begin
            errors++;
            $display("FAIL prio_mem_alu: fwdb=%b, required 10", bus.fwdb);
        end
        bus.ewreg = 1; bus.em2reg = 1;
        tick();
        bus.ewreg = 0; bus.em2reg = 0;
        #1;
        checks++;
        if (bus.fwdb !== 2'b11 || bus.mm2reg !== 1'b1) begin
            errors++;
            $display("FAIL prio_mem_load: fwdb=%b mm2reg=%b, required 11 1", bus.fwdb, bus.mm2reg);
        end
    endtask

    task automatic test_load_use();
        bus.ewreg = 1; bus.em2reg = 1; bus.ern = 5'd7;
        bus.drs = 5'd7; bus.duse_rs = 1; bus.drt = 5'd0; bus.duse_rt = 0;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.fwda !== 2'b00) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b fwda=%b, required 1 00", bus.stall, bus.fwda);
        end
        tick();
        bus.ewreg = 0; bus.em2reg = 0; bus.ern = 5'd0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.fwda !== 2'b11) begin
            errors++;
            $display("FAIL load_use_resolve: stall=%b fwda=%b, required 0 11", bus.stall, bus.fwda);
        end
        bus.ewreg = 1; bus.em2reg = 1; bus.ern = 5'd7; bus.duse_rs = 0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_unused: stall=%b, required 0", bus.stall);
        end
    endtask

    task automatic test_hold();
        idle_inputs();
        bus.ealu = 32'hA5A5_A5A5;
        tick();
        bus.mem_hold = 1;
        for (int i = 0; i < 3; i++) begin
            bus.ealu = $urandom;
            #1;
            checks++;
            if (bus.stall !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall[%0d]: stall=%b, required 1", i, bus.stall);
            end
            tick();
            checks++;
            if (bus.malu !== 32'hA5A5_A5A5) begin
                errors++;
                $display("FAIL hold_malu[%0d]: malu=%h, required a5a5a5a5", i, bus.malu);
            end
        end
        bus.mem_hold = 0;
        bus.ealu = 32'h0BAD_F00D;
        tick();
        checks++;
        if (bus.malu !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL hold_release: malu=%h, required 0badf00d", bus.malu);
        end
    endtask

`ifdef PIPE_HAZARD_CNT_EN
    task automatic test_counters();
        idle_inputs();
        resetn = 0;
        tick();
        resetn = 1;
        bus.ewreg = 1; bus.em2reg = 1; bus.ern = 5'd7; bus.drs = 5'd7; bus.duse_rs = 1;
        for (int i = 0; i < 4; i++) tick();
        bus.ewreg = 0; bus.em2reg = 0; bus.ern = 5'd0; bus.duse_rs = 0;
        bus.mem_hold = 1;
        for (int i = 0; i < 2; i++) tick();
        bus.mem_hold = 0;
        checks++;
        if (stall_cnt !== 32'd4) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, required 4", stall_cnt);
        end
        checks++;
        if (fwd_cnt !== 32'd0) begin
            errors++;
            $display("FAIL fwd_cnt_idle: got %0d, required 0", fwd_cnt);
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            resetn       = ($urandom_range(0, 39) != 0);
            bus.ewreg    = $urandom_range(0, 1);
            bus.em2reg   = ($urandom_range(0, 2) == 0);
            bus.ewmem    = $urandom_range(0, 1);
            bus.ealu     = $urandom;
            bus.eb       = $urandom;
            bus.ern      = 5'($urandom_range(0, 3));
            bus.mem_hold = ($urandom_range(0, 7) == 0);
            bus.drs      = 5'($urandom_range(0, 3));
            bus.drt      = 5'($urandom_range(0, 3));
            bus.duse_rs  = $urandom_range(0, 1);
            bus.duse_rt  = $urandom_range(0, 1);
            #1;
            checks++;
            if (bus.mwreg !== exp_mwreg || bus.mm2reg !== exp_mm2reg || bus.mwmem !== exp_mwmem ||
                bus.malu !== exp_malu || bus.mb !== exp_mb || bus.mrn !== exp_mrn) begin
                errors++;
                $display("FAIL rand_mreg[%0d]: got %b%b%b %h %h %0d, required %b%b%b %h %h %0d", n,
                         bus.mwreg, bus.mm2reg, bus.mwmem, bus.malu, bus.mb, bus.mrn,
                         exp_mwreg, exp_mm2reg, exp_mwmem, exp_malu, exp_mb, exp_mrn);
            end
            checks++;
            if (bus.fwda !== ref_sel(bus.drs, bus.duse_rs) || bus.fwdb !== ref_sel(bus.drt, bus.duse_rt) ||
                bus.stall !== (ref_load_use() || bus.mem_hold)) begin
                errors++;
                $display("FAIL rand_hazard[%0d]: fwda=%b fwdb=%b stall=%b, required %b %b %b", n,
                         bus.fwda, bus.fwdb, bus.stall, ref_sel(bus.drs, bus.duse_rs),
                         ref_sel(bus.drt, bus.duse_rt), ref_load_use() || bus.mem_hold);
            end
`ifdef PIPE_HAZARD_CNT_EN
            checks++;
            if (stall_cnt !== exp_stall_cnt || fwd_cnt !== exp_fwd_cnt) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: stall_cnt=%0d fwd_cnt=%0d, required %0d %0d", n,
                         stall_cnt, fwd_cnt, exp_stall_cnt, exp_fwd_cnt);
            end
`endif
            tick();
        end
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        #2;
        test_reset();
        test_exe_fwd();
        test_priority();
        test_load_use();
        test_hold();
`ifdef PIPE_HAZARD_CNT_EN
        test_counters();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
